// File: rtl/aes_seq_pkg.sv
// Shared definitions for the iterative AES round sequencer: whitening seed,
// default round count, state type and FSM encoding.
package aes_seq_pkg;

  localparam int          NUM_ROUNDS_DEF = 10;
  localparam int          STATE_W        = 128;
  localparam logic [127:0] AES_SEED      = 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa0a;

  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/aes_round_seq.sv
// Iterative sequencer: whitens an accepted key, loops it through one shared
// round datapath NUM_ROUNDS times, then offers the result over valid/ready.
module aes_round_seq
  import aes_seq_pkg::*;
#(
  parameter int                NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int                ROUND_LAT  = 1,
  parameter int                DATA_W     = 128,
  parameter logic [DATA_W-1:0] SEED       = DATA_W'(AES_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] rnd_in,
  output logic [DATA_W-1:0] rnd_const,
  input  logic [DATA_W-1:0] rnd_out,
  output logic              busy,
  output logic [3:0]        round_idx
);

  localparam logic [2:0] LAT_LAST   = 3'(ROUND_LAT);
  localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS - 1);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] st_q, st_d;
  logic [3:0]        round_q, round_d;
  logic [2:0]        lat_q, lat_d;

  // NOTE: every state register sits on the async reset, so a reset mid-job
  // leaves no stale partial state behind; non-blocking assignments keep all
  // registers updating from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      round_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      round_q <= round_d;
      lat_q   <= lat_d;
    end
  end

  // NOTE: next-state signals default to holding their current value before
  // the case statement, so no path through it can infer a latch.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    round_d = round_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_key ^ SEED;
          round_d = '0;
          lat_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // rnd_out is only trusted once the datapath latency has elapsed.
        if (lat_q == LAT_LAST) begin
          st_d  = rnd_out;
          lat_d = '0;
          if (round_q == ROUND_LAST) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rnd_in    = st_q;
  assign out_data  = st_q;
  assign rnd_const = SEED;
  assign round_idx = round_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Self-checking bench: two sequencers (1-cycle and 3-cycle round stubs that
// add one to the state) compared against an arithmetic reference model.
module tb_aes_round_seq;
  import aes_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [127:0] a_in_key, a_out_data, a_rnd_in, a_rnd_const, a_rnd_out;
  logic [3:0]   a_round_idx;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [127:0] b_in_key, b_out_data, b_rnd_in, b_rnd_const, b_rnd_out;
  logic [3:0]   b_round_idx;
  logic [127:0] b_p1, b_p2;

  aes_round_seq #(.ROUND_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_key(a_in_key),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .rnd_in(a_rnd_in), .rnd_const(a_rnd_const), .rnd_out(a_rnd_out),
    .busy(a_busy), .round_idx(a_round_idx)
  );

  aes_round_seq #(.ROUND_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_key(b_in_key),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .rnd_in(b_rnd_in), .rnd_const(b_rnd_const), .rnd_out(b_rnd_out),
    .busy(b_busy), .round_idx(b_round_idx)
  );

  // Round stubs: registered increment, one stage for A, three for B.
  always_ff @(posedge clk) a_rnd_out <= a_rnd_in + 128'd1;
  always_ff @(posedge clk) begin
    b_p1      <= b_rnd_in + 128'd1;
    b_p2      <= b_p1;
    b_rnd_out <= b_p2;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Whitening, then NUM_ROUNDS applications of the +1 stub.
  function automatic logic [127:0] ref_result(input logic [127:0] key);
    logic [127:0] s;
    s = key ^ AES_SEED;
    for (int r = 0; r < NUM_ROUNDS_DEF; r++) s = s + 128'd1;
    return s;
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [127:0] key);
    a_in_key   = key;
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge until out_valid; also tracks that
  // round_idx advances once every two cycles.
  task automatic wait_a(output int cyc, output bit idx_ok);
    cyc    = 0;
    idx_ok = 1'b1;
    while (a_out_valid !== 1'b1 && cyc < 200) begin
      if (a_round_idx !== 4'(cyc / 2)) idx_ok = 1'b0;
      step();
      cyc++;
    end
  endtask

  task automatic wait_b(output int cyc);
    cyc = 0;
    while (b_out_valid !== 1'b1 && cyc < 400) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    int           cyc;
    bit           idx_ok;
    bit           stray;
    logic [127:0] key;

    rst_n       = 1'b0;
    a_in_valid  = 1'b0; a_in_key = '0; a_out_ready = 1'b1;
    b_in_valid  = 1'b0; b_in_key = '0; b_out_ready = 1'b1;
    #1;
    check("rst_out_valid", 128'(a_out_valid), 128'd0);
    check("rst_out_data",  a_out_data, 128'd0);
    check("rst_busy",      128'(a_busy), 128'd0);
    check("rst_round_idx", 128'(a_round_idx), 128'd0);
    check("rst_in_ready",  128'(a_in_ready), 128'd1);
    check("rst_b_idle",    128'({b_busy, b_out_valid, b_in_ready, b_round_idx}), 128'b0010000);
    check("rnd_const",     a_rnd_const, AES_SEED);
    step(); step();
    rst_n = 1'b1;
    step();

    // Basic job, key 0
    start_a(128'd0);
    check("basic_busy", 128'(a_busy), 128'd1);
    wait_a(cyc, idx_ok);
    check("basic_latency", 128'(cyc), 128'd20);
    check("basic_round_idx", 128'(idx_ok), 128'd1);
    check("basic_data", a_out_data, 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa14);
    step();
    check("basic_back_idle", 128'({a_in_ready, a_out_valid}), 128'b10);

    // Wrap-around: whitened state is all ones
    start_a(~AES_SEED);
    wait_a(cyc, idx_ok);
    check("wrap_data", a_out_data, 128'd9);
    step();

    // Random keys
    for (int i = 0; i < 3; i++) begin
      key = rand_key();
      start_a(key);
      wait_a(cyc, idx_ok);
      check("rand_latency", 128'(cyc), 128'd20);
      check("rand_data", a_out_data, ref_result(key));
      step();
    end

    // Backpressure: result must hold and new keys be ignored
    a_out_ready = 1'b0;
    key = rand_key();
    start_a(key);
    wait_a(cyc, idx_ok);
    check("bp_data", a_out_data, ref_result(key));
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1;
      a_in_key   = ~key;
      step();
      check("bp_hold", 128'({a_out_valid, a_in_ready}), 128'b10);
      check("bp_stable", a_out_data, ref_result(key));
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    check("bp_release", 128'({a_in_ready, a_busy, a_out_valid}), 128'b100);
    step();
    check("bp_no_ghost_job", 128'(a_busy), 128'd0);

    // Back-to-back: key 0 then key 1 with in_valid held
    a_in_key   = 128'd0;
    a_in_valid = 1'b1;
    step();
    a_in_key = 128'd1;
    wait_a(cyc, idx_ok);
    check("b2b_latency0", 128'(cyc), 128'd20);
    check("b2b_data0", a_out_data, ref_result(128'd0));
    step();
    check("b2b_gap_ready", 128'(a_in_ready), 128'd1);
    step();
    check("b2b_accept1", 128'(a_busy), 128'd1);
    a_in_valid = 1'b0;
    wait_a(cyc, idx_ok);
    check("b2b_latency1", 128'(cyc), 128'd20);
    check("b2b_data1", a_out_data, ref_result(128'd1));
    step();

    // Reset mid-job at round 4
    start_a(rand_key());
    cyc = 0;
    while (a_round_idx !== 4'd4 && cyc < 100) begin
      step();
      cyc++;
    end
    check("mid_reach_round4", 128'(a_round_idx), 128'd4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", 128'({a_out_valid, a_busy, a_in_ready, a_round_idx}), 128'b0010000);
    check("mid_rst_data", a_out_data, 128'd0);
    step();
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (a_out_valid !== 1'b0) stray = 1'b1;
      step();
    end
    check("mid_no_output", 128'(stray), 128'd0);
    key = rand_key();
    start_a(key);
    wait_a(cyc, idx_ok);
    check("mid_new_latency", 128'(cyc), 128'd20);
    check("mid_new_data", a_out_data, ref_result(key));
    step();

    // Three-cycle round datapath
    b_in_key   = 128'd0;
    b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    wait_b(cyc);
    check("lat3_latency", 128'(cyc), 128'd40);
    check("lat3_data", b_out_data, 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa14);
    step();
    key = rand_key();
    b_in_key   = key;
    b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    wait_b(cyc);
    check("lat3_rand_latency", 128'(cyc), 128'd40);
    check("lat3_rand_data", b_out_data, ref_result(key));
    step();
    check("lat3_idle", 128'({b_in_ready, b_busy}), 128'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
